// File: rtl/button_debouncer.sv
// Debounces a raw, asynchronous button: a two-flop synchronizer feeds a
// counter-qualified FSM that accepts a new level after STABLE_COUNT stable cycles.
module button_debouncer #(
  parameter int STABLE_COUNT  = 20000,
  parameter int COUNTER_WIDTH = 15
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_busy
);

  // Encoding puts the output level in bit 1 and the busy flag in bit 0,
  // so both outputs come straight from state flops.
  typedef enum logic [1:0] {
    S_LOW     = 2'b00,
    WAIT_HIGH = 2'b01,
    S_HIGH    = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(STABLE_COUNT - 1);

  logic                     sync1, sync2;
  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] cnt, cnt_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      S_LOW:     if (sync2) state_next = WAIT_HIGH;
      WAIT_HIGH: begin
        if (!sync2)           state_next = S_LOW;
        else if (cnt == LAST) state_next = S_HIGH;
        else                  cnt_next   = cnt + 1'b1;
      end
      S_HIGH:    if (!sync2) state_next = WAIT_LOW;
      WAIT_LOW:  begin
        if (sync2)            state_next = S_HIGH;
        else if (cnt == LAST) state_next = S_LOW;
        else                  cnt_next   = cnt + 1'b1;
      end
      default:   state_next = S_LOW;
    endcase
  end

  assign o_level = state[1];
  assign o_busy  = state[0];

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (STABLE_COUNT=4): run-length reference model
// checked every cycle, plus literal edge-by-edge expectations per scenario.
module tb_button_debouncer;
  localparam int SC = 4;
  localparam int CW = 3;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_raw   = 1'b0;
  logic o_level, o_busy;

  int total = 0;
  int bad   = 0;

  button_debouncer #(.STABLE_COUNT(SC), .COUNTER_WIDTH(CW)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_raw(i_raw),
    .o_level(o_level), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Reference: raw seen two edges late; a level is accepted after SC+1
  // consecutive observations that differ from the current output.
  bit d1, d2, m_lvl, m_valid;
  int run;
  always @(posedge i_clock) begin
    if (i_reset) begin
      d1 = 0; d2 = 0; m_lvl = 0; run = 0; m_valid = 1;
    end else begin
      if (d2 != m_lvl) begin
        run++;
        if (run == SC + 1) begin m_lvl = d2; run = 0; end
      end else run = 0;
      d2 = d1;
      d1 = i_raw;
    end
    #1;
    if (m_valid) begin
      total++;
      if (o_level !== m_lvl) begin
        bad++;
        $display("FAIL model_level t=%0t got=%b want=%b", $time, o_level, m_lvl);
      end
      total++;
      if (o_busy !== (run > 0)) begin
        bad++;
        $display("FAIL model_busy t=%0t got=%b want=%b", $time, o_busy, run > 0);
      end
    end
  end

  // Downstream rising-edge detector with a registered strobe.
  logic lvl_d = 1'b0, pulse = 1'b0;
  always @(posedge i_clock) begin
    lvl_d <= o_level;
    pulse <= o_level & ~lvl_d;
  end

  int pulse_cnt;
  bit pulse_seen;

  task automatic step(input logic raw, input logic rst);
    @(negedge i_clock);
    i_raw   = raw;
    i_reset = rst;
    @(posedge i_clock);
    #2;
    if (pulse) pulse_cnt++;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    // 1: reset with raw toggling
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b1);
      chk("rst_level", o_level, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("post_rst_level", o_level, 1'b0);
    chk("post_rst_busy", o_busy, 1'b0);
    repeat (2) step(1'b0, 1'b0);

    // 2: clean press, edge 0 is the first step with raw high
    for (int e = 0; e <= 6; e++) begin
      step(1'b1, 1'b0);
      chk("press_level", o_level, e >= 6);
      chk("press_busy", o_busy, e >= 2 && e < 6);
    end
    repeat (3) step(1'b1, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 1'b0);
      chk("release_level", o_level, !(e >= 6));
      chk("release_busy", o_busy, e >= 2 && e < 6);
    end
    repeat (3) step(1'b0, 1'b0);

    // 3 + 6: bounce rejection, then a real press through the edge detector
    pulse_cnt  = 0;
    pulse_seen = 0;
    begin
      logic [13:0] pat;
      pat = 14'b11101100000000;
      for (int i = 13; i >= 0; i--) begin
        step(pat[i], 1'b0);
        chk("bounce_level", o_level, 1'b0);
        if (o_busy) pulse_seen = 1;
      end
    end
    chk("bounce_busy_seen", pulse_seen, 1'b1);
    chk("bounce_no_pulse", pulse_cnt == 0, 1'b1);
    for (int e = 0; e <= 7; e++) begin
      step(1'b1, 1'b0);
      chk("bounce_press_level", o_level, e >= 6);
      if (e == 7) chk("strobe_cycle_after", pulse, 1'b1);
    end
    repeat (4) step(1'b1, 1'b0);
    chk("one_strobe", pulse_cnt == 1, 1'b1);

    // 4: release bounce from S_HIGH
    for (int e = 0; e <= 7; e++) begin
      step(e >= 3, 1'b0);
      chk("relbounce_level", o_level, 1'b1);
      chk("relbounce_busy", o_busy, e >= 2 && e <= 4);
    end

    // 5: reset while WAIT_HIGH with cnt=2
    repeat (8) step(1'b0, 1'b0);
    for (int e = 0; e <= 4; e++) step(1'b1, 1'b0);
    chk("pre_abort_busy", o_busy, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_level", o_level, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      step(1'b1, 1'b0);
      chk("requal_level", o_level, e >= 6);
      chk("requal_busy", o_busy, e >= 2 && e < 6);
    end
    repeat (3) step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
